// File: rtl/dbus_loader_pkg.sv
// rtl/dbus_loader_pkg.sv - opcodes, FSM encoding and constants for the dBus loader
package dbus_loader_pkg;

  localparam logic [7:0] OP_WRITE   = 8'h01;
  localparam logic [7:0] OP_READ    = 8'h02;
  localparam logic [7:0] OP_WRNEXT  = 8'h03;
  localparam logic [7:0] OP_HOLD    = 8'h04;
  localparam logic [7:0] OP_RELEASE = 8'h05;
  localparam logic [7:0] OP_CLRERR  = 8'h06;

  localparam logic [7:0]  ACK_BYTE  = 8'hA5;
  localparam logic [7:0]  NAK_BYTE  = 8'hE5;
  localparam logic [31:0] DEADBEEF  = 32'hDEADBEEF;
  localparam logic [1:0]  SIZE_WORD = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_CMD,
    ST_RSP,
    ST_TX,
    ST_ACK
  } state_e;

  // Bytes arrive little-endian, so each new byte becomes the current top byte.
  function automatic logic [31:0] shift_le(input logic [31:0] cur, input logic [7:0] b);
    return {b, cur[31:8]};
  endfunction

endpackage

// File: rtl/dbus_loader_ser.sv
// rtl/dbus_loader_ser.sv - 32-bit word to 4-byte little-endian valid/ready serializer
module dbus_loader_ser (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        load_i,
  input  logic [31:0] load_data_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [7:0]  out_data_o,
  output logic        done_o
);

  logic [31:0] word_q, word_d;
  logic [1:0]  idx_q, idx_d;
  logic        busy_q, busy_d;

  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    busy_d = busy_q;
    if (load_i && !busy_q) begin
      word_d = load_data_i;
      idx_d  = 2'd0;
      busy_d = 1'b1;
    end else if (busy_q && out_ready_i) begin
      idx_d = idx_q + 2'd1;
      if (idx_q == 2'd3) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      word_q <= '0;
      idx_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
      busy_q <= busy_d;
    end
  end

  assign out_valid_o = busy_q;
  assign out_data_o  = word_q[{idx_q, 3'b000} +: 8];
  assign done_o      = busy_q && out_ready_i && (idx_q == 2'd3);

endmodule

// File: rtl/dbus_loader.sv
// rtl/dbus_loader.sv - byte-stream command decoder driving single-word dBus reads/writes
// DBUS_LOADER_ACK_EN: write/control commands return one ACK (A5) or NAK (E5) byte.
module dbus_loader
  import dbus_loader_pkg::*;
#(
  parameter int unsigned RSP_TIMEOUT   = 64,
  parameter bit          HOLD_AT_RESET = 1'b0
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [7:0]  in_data_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [7:0]  out_data_o,
  output logic        dbus_cmd_valid_o,
  input  logic        dbus_cmd_ready_i,
  output logic        dbus_cmd_wr_o,
  output logic [31:0] dbus_cmd_address_o,
  output logic [31:0] dbus_cmd_data_o,
  output logic [1:0]  dbus_cmd_size_o,
  input  logic        dbus_rsp_ready_i,
  input  logic        dbus_rsp_error_i,
  input  logic [31:0] dbus_rsp_data_i,
  output logic        cpu_hold_o,
  output logic        err_sticky_o
);

  localparam int unsigned      TW         = $clog2(RSP_TIMEOUT + 1);
  localparam logic [TW-1:0]    TIMER_LAST = TW'(RSP_TIMEOUT - 1);

`ifdef DBUS_LOADER_ACK_EN
  localparam state_e AFTER_WR = ST_ACK;
`else
  localparam state_e AFTER_WR = ST_IDLE;
`endif

  state_e          state_q, state_d;
  logic [7:0]      op_q, op_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     data_q, data_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            hold_q, hold_d;
  logic            err_q, err_d;

  logic            in_fire;
  logic            is_write;
  logic            rsp_timeout;
  logic            ser_load;
  logic [31:0]     rd_word;
  logic            ser_valid;
  logic [7:0]      ser_data;
  logic            ser_done;

  assign in_fire     = in_valid_i && in_ready_o;
  assign is_write    = (op_q != OP_READ);
  assign rsp_timeout = (timer_q == TIMER_LAST);
  assign rd_word     = (dbus_rsp_ready_i && !dbus_rsp_error_i) ? dbus_rsp_data_i : DEADBEEF;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (in_fire) begin
          case (in_data_i)
            OP_WRITE, OP_READ:                  state_d = ST_ADDR;
            OP_WRNEXT:                          state_d = ST_DATA;
            OP_HOLD, OP_RELEASE, OP_CLRERR:     state_d = AFTER_WR;
            default:                            state_d = ST_IDLE;
          endcase
        end
      end
      ST_ADDR: begin
        if (in_fire && cnt_q == 2'd3) begin
          state_d = (op_q == OP_READ) ? ST_CMD : ST_DATA;
        end
      end
      ST_DATA: begin
        if (in_fire && cnt_q == 2'd3) begin
          state_d = ST_CMD;
        end
      end
      ST_CMD: begin
        if (dbus_cmd_ready_i) begin
          state_d = is_write ? AFTER_WR : ST_RSP;
        end
      end
      ST_RSP: begin
        if (dbus_rsp_ready_i || rsp_timeout) begin
          state_d = ST_TX;
        end
      end
      ST_TX: begin
        if (ser_done) begin
          state_d = ST_IDLE;
        end
      end
      ST_ACK: begin
        if (out_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs are forced low while reset is asserted.
  always_comb begin
    in_ready_o       = 1'b0;
    dbus_cmd_valid_o = 1'b0;
    ser_load         = 1'b0;
    case (state_q)
      ST_IDLE, ST_ADDR, ST_DATA: in_ready_o = !reset_i;
      ST_CMD:                    dbus_cmd_valid_o = !reset_i;
      ST_RSP:                    ser_load = dbus_rsp_ready_i || rsp_timeout;
      default: ;
    endcase
    out_valid_o = !reset_i && (ser_valid || state_q == ST_ACK);
    out_data_o  = (state_q == ST_ACK) ? (err_q ? NAK_BYTE : ACK_BYTE) : ser_data;
  end

  assign dbus_cmd_wr_o      = is_write;
  assign dbus_cmd_address_o = addr_q;
  assign dbus_cmd_data_o    = data_q;
  assign dbus_cmd_size_o    = SIZE_WORD;
  assign cpu_hold_o         = hold_q;
  assign err_sticky_o       = err_q;

  always_comb begin
    op_d    = op_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    timer_d = timer_q;
    hold_d  = hold_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (in_fire) begin
          op_d  = in_data_i;
          cnt_d = 2'd0;
          case (in_data_i)
            OP_WRITE, OP_READ, OP_WRNEXT: ;
            OP_HOLD:    hold_d = 1'b1;
            OP_RELEASE: hold_d = 1'b0;
            OP_CLRERR:  err_d  = 1'b0;
            default:    err_d  = 1'b1;
          endcase
        end
      end
      ST_ADDR: begin
        if (in_fire) begin
          cnt_d  = cnt_q + 2'd1;
          addr_d = shift_le(addr_q, in_data_i);
          if (cnt_q == 2'd3) begin
            addr_d[1:0] = 2'b00;
          end
        end
      end
      ST_DATA: begin
        if (in_fire) begin
          cnt_d  = cnt_q + 2'd1;
          data_d = shift_le(data_q, in_data_i);
        end
      end
      ST_CMD: begin
        if (dbus_cmd_ready_i) begin
          timer_d = '0;
          if (is_write) begin
            addr_d = addr_q + 32'd4;
          end
        end
      end
      ST_RSP: begin
        timer_d = timer_q + 1'b1;
        if (dbus_rsp_ready_i ? dbus_rsp_error_i : rsp_timeout) begin
          err_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      op_q    <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      timer_q <= '0;
      hold_q  <= HOLD_AT_RESET;
      err_q   <= 1'b0;
    end else begin
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      timer_q <= timer_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
    end
  end

  dbus_loader_ser u_ser (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .load_i      (ser_load),
    .load_data_i (rd_word),
    .out_valid_o (ser_valid),
    .out_ready_i (out_ready_i),
    .out_data_o  (ser_data),
    .done_o      (ser_done)
  );

endmodule

// File: tb/tb_dbus_loader.sv
// tb/tb_dbus_loader.sv - directed self-checking bench for dbus_loader
module tb_dbus_loader;

  localparam int unsigned TO = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [7:0]  in_data;
  logic        out_valid, out_ready;
  logic [7:0]  out_data;
  logic        cmd_valid, cmd_ready, cmd_wr;
  logic [31:0] cmd_addr, cmd_data;
  logic [1:0]  cmd_size;
  logic        rsp_ready, rsp_error;
  logic [31:0] rsp_data;
  logic        cpu_hold, err_sticky;

  always #5 clk = ~clk;

  dbus_loader #(.RSP_TIMEOUT(TO), .HOLD_AT_RESET(1'b0)) dut (
    .clk_i              (clk),
    .reset_i            (reset),
    .in_valid_i         (in_valid),
    .in_ready_o         (in_ready),
    .in_data_i          (in_data),
    .out_valid_o        (out_valid),
    .out_ready_i        (out_ready),
    .out_data_o         (out_data),
    .dbus_cmd_valid_o   (cmd_valid),
    .dbus_cmd_ready_i   (cmd_ready),
    .dbus_cmd_wr_o      (cmd_wr),
    .dbus_cmd_address_o (cmd_addr),
    .dbus_cmd_data_o    (cmd_data),
    .dbus_cmd_size_o    (cmd_size),
    .dbus_rsp_ready_i   (rsp_ready),
    .dbus_rsp_error_i   (rsp_error),
    .dbus_rsp_data_i    (rsp_data),
    .cpu_hold_o         (cpu_hold),
    .err_sticky_o       (err_sticky)
  );

  int          n_assert = 0;
  int          n_fail = 0;
  logic [7:0]  out_q[$];
  int          cmd_count = 0;
  logic [31:0] last_addr = '0;
  logic [31:0] last_data = '0;
  logic        last_wr = 1'b0;
  logic [1:0]  last_size = '0;
  int          base;

  // Handshakes are sampled mid-cycle; inputs only change just after posedge.
  always @(negedge clk) begin
    if (!reset && cmd_valid && cmd_ready) begin
      cmd_count++;
      last_addr = cmd_addr;
      last_data = cmd_data;
      last_wr   = cmd_wr;
      last_size = cmd_size;
    end
    if (!reset && out_valid && out_ready) begin
      out_q.push_back(out_data);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", 32'(n < 200), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_n(input int n, input logic [71:0] bytes);
    for (int i = 0; i < n; i++) begin
      send_byte(bytes[8*(n-1-i) +: 8]);
    end
  endtask

  task automatic wait_out(input int k);
    int n;
    n = 0;
    while (out_q.size() < k && n < 500) begin
      tick();
      n++;
    end
    chk("out_bytes_wait", 32'(out_q.size() >= k), 32'd1);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    cmd_ready = 1'b1; rsp_ready = 1'b0; rsp_error = 1'b0; rsp_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("rst_cpu_hold", 32'(cpu_hold), 32'd0);
    chk("rst_err", 32'(err_sticky), 32'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    tick();

    // T1 WRITE
    out_q.delete();
    send_n(9, 72'h01_10000000_78563412);
    repeat (3) tick();
    chk("t1_cmd_count", 32'(cmd_count), 32'd1);
    chk("t1_addr", last_addr, 32'h0000_0010);
    chk("t1_data", last_data, 32'h1234_5678);
    chk("t1_wr", 32'(last_wr), 32'd1);
    chk("t1_size", 32'(last_size), 32'd2);
`ifdef DBUS_LOADER_ACK_EN
    chk("t1_ack_count", 32'(out_q.size()), 32'd1);
    chk("t1_ack_byte", 32'(out_q[0]), 32'hA5);
`else
    chk("t1_no_out", 32'(out_q.size()), 32'd0);
`endif

    // T2 WRNEXT with bus stall
    cmd_ready = 1'b0;
    send_n(5, 72'h03_EFBEADDE);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_stall_valid", 32'(cmd_valid), 32'd1);
      chk("t2_stall_addr", cmd_addr, 32'h0000_0014);
      chk("t2_stall_data", cmd_data, 32'hDEAD_BEEF);
      chk("t2_stall_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    cmd_ready = 1'b1;
    repeat (3) tick();
    chk("t2_cmd_count", 32'(cmd_count), 32'd2);
    chk("t2_addr", last_addr, 32'h0000_0014);
    chk("t2_valid_drop", 32'(cmd_valid), 32'd0);
    send_n(5, 72'h03_01000000);
    repeat (3) tick();
    chk("t2_next_addr", last_addr, 32'h0000_0018);
    chk("t2_next_data", last_data, 32'h0000_0001);

    // T3 READ with response after one cycle, output back-pressure
    repeat (2) tick();
    out_q.delete();
    send_n(5, 72'h02_13000080);
    @(negedge clk);
    chk("t3_cmd_valid", 32'(cmd_valid), 32'd1);
    chk("t3_addr", cmd_addr, 32'h8000_0010);
    chk("t3_wr", 32'(cmd_wr), 32'd0);
    tick();
    tick();
    rsp_ready = 1'b1;
    rsp_data  = 32'hCAFE_F00D;
    out_ready = 1'b0;
    tick();
    rsp_ready = 1'b0;
    rsp_data  = '0;
    @(negedge clk);
    chk("t3_first_valid", 32'(out_valid), 32'd1);
    chk("t3_first_byte", 32'(out_data), 32'h0D);
    tick();
    @(negedge clk);
    chk("t3_held_byte", 32'(out_data), 32'h0D);
    chk("t3_tx_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    wait_out(4);
    chk("t3_b0", 32'(out_q[0]), 32'h0D);
    chk("t3_b1", 32'(out_q[1]), 32'hF0);
    chk("t3_b2", 32'(out_q[2]), 32'hFE);
    chk("t3_b3", 32'(out_q[3]), 32'hCA);
    chk("t3_err", 32'(err_sticky), 32'd0);

    // Stray response outside RSP is ignored
    tick();
    rsp_ready = 1'b1;
    rsp_error = 1'b1;
    tick();
    rsp_ready = 1'b0;
    rsp_error = 1'b0;
    tick();
    chk("stray_rsp_err", 32'(err_sticky), 32'd0);
    chk("stray_rsp_out", 32'(out_valid), 32'd0);

    // T4 READ timeout
    out_q.delete();
    send_n(5, 72'h02_00010000);
    tick();
    base = 0;
    while (!out_valid && base < 300) begin
      tick();
      base++;
    end
    chk("t4_timeout_cycles", 32'(base), 32'(TO));
    chk("t4_err", 32'(err_sticky), 32'd1);
    wait_out(4);
    chk("t4_b0", 32'(out_q[0]), 32'hEF);
    chk("t4_b1", 32'(out_q[1]), 32'hBE);
    chk("t4_b2", 32'(out_q[2]), 32'hAD);
    chk("t4_b3", 32'(out_q[3]), 32'hDE);
    tick();
    send_byte(8'h06);
    chk("t4_clrerr", 32'(err_sticky), 32'd0);
    repeat (3) tick();

    // T5 HOLD, bad opcode, RELEASE
    send_byte(8'h04);
    chk("t5_hold", 32'(cpu_hold), 32'd1);
    repeat (3) tick();
    out_q.delete();
    base = cmd_count;
    send_byte(8'h7F);
    chk("t5_bad_err", 32'(err_sticky), 32'd1);
    repeat (3) tick();
    chk("t5_no_cmd", 32'(cmd_count), 32'(base));
    chk("t5_idle", 32'(in_ready), 32'd1);
    chk("t5_hold_kept", 32'(cpu_hold), 32'd1);
    send_byte(8'h05);
    chk("t5_release", 32'(cpu_hold), 32'd0);
    repeat (3) tick();
`ifdef DBUS_LOADER_ACK_EN
    chk("t5_nak_count", 32'(out_q.size()), 32'd1);
    chk("t5_nak_byte", 32'(out_q[0]), 32'hE5);
`else
    chk("t5_no_out", 32'(out_q.size()), 32'd0);
`endif
    send_byte(8'h06);
    repeat (3) tick();

    // T6 reset mid-address, then reset during CMD
    out_q.delete();
    base = cmd_count;
    send_n(3, 72'h01_AABB);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_rst_in_ready", 32'(in_ready), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    cmd_ready = 1'b0;
    send_n(9, 72'h01_30000000_04030201);
    @(negedge clk);
    chk("t6_cmd_pending", 32'(cmd_valid), 32'd1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("t6_cmd_dropped", 32'(cmd_valid), 32'd0);
    chk("t6_no_accept", 32'(cmd_count), 32'(base));
    cmd_ready = 1'b1;
    tick();
    send_n(9, 72'h01_20000000_44332211);
    repeat (3) tick();
    chk("t6_cmd_count", 32'(cmd_count), 32'(base + 1));
    chk("t6_addr", last_addr, 32'h0000_0020);
    chk("t6_data", last_data, 32'h1122_3344);
`ifdef DBUS_LOADER_ACK_EN
    chk("t6_out_count", 32'(out_q.size()), 32'd1);
`else
    chk("t6_out_count", 32'(out_q.size()), 32'd0);
`endif
    chk("t6_hold", 32'(cpu_hold), 32'd0);
    chk("t6_err", 32'(err_sticky), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
